// File: rtl/dec_pkg.sv
// ---------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the LFSR frame decryptor: controller state
// encoding, frame geometry, the table of candidate feedback patterns and
// two small helpers that summarise the candidate mask at the end of training.
// Configuration macro used by the design: DEC_PARITY_CHECK_EN (see lfsr_decrypt).
// ---------------------------------------------------------------------------
package dec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRAIN,
        DECODE,
        DRAIN,
        DONE
    } state_e;

    localparam int FRAME_LEN = 64;
    localparam int TRAIN_LEN = 10;
    localparam int NUM_PTRN  = 9;

    localparam logic [6:0] LFSR_PTRN [NUM_PTRN] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    // Index of the lowest surviving candidate; zero when nothing survived.
    function automatic logic [3:0] lowestSet(input logic [NUM_PTRN-1:0] m);
        logic [3:0] r;
        r = '0;
        for (int i = NUM_PTRN - 1; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    // True when at least two candidates survived (clearing the lowest set
    // bit still leaves something behind).
    function automatic logic multiSet(input logic [NUM_PTRN-1:0] m);
        return (m & (m - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// ---------------------------------------------------------------------------
// lfsr_next
// Combinational one-step advance of a 7-bit Fibonacci-style LFSR: the state
// shifts left by one and the new LSB is the parity of the tapped bits.
// Ports:
//   state_i  current 7-bit state
//   ptrn_i   7-bit tap pattern
//   next_o   state after one step
// ---------------------------------------------------------------------------
module lfsr_next (
    input  logic [6:0] state_i,
    input  logic [6:0] ptrn_i,
    output logic [6:0] next_o
);

    assign next_o = {state_i[5:0], ^(state_i & ptrn_i)};

endmodule

// File: rtl/lfsr_decrypt.sv
// ---------------------------------------------------------------------------
// lfsr_decrypt
// Decrypts a 64-byte frame whose keystream comes from a 7-bit LFSR with an
// unknown tap pattern (one of nine) and unknown seed. The first ten bytes are
// encrypted spaces, so they expose the raw LFSR sequence: byte 0 is the seed
// and bytes 1..9 eliminate every pattern that does not predict them. The
// remaining bytes are decrypted with the surviving pattern. Leading spaces
// are dropped; everything from the first printable character on is emitted.
// Ports:
//   Clk, Reset            clock; synchronous active-low reset
//   Start                 launches a frame (from IDLE or DONE)
//   InData/InValid/InReady    encrypted byte stream (bit 7 = parity)
//   OutData/OutValid/OutReady plaintext byte stream
//   Done                  frame finished, held until the next Start
//   TapIdx, LfsrInit      detected pattern index and seed
//   NoMatch, Ambig        no candidate survived / several survived
//   ParErrCnt             saturating parity error count
// Optional feature: define DEC_PARITY_CHECK_EN to count parity errors;
// otherwise bit 7 is ignored and ParErrCnt reads zero.
// ---------------------------------------------------------------------------
module lfsr_decrypt
    import dec_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] InData,
    input  logic       InValid,
    output logic       InReady,
    output logic [7:0] OutData,
    output logic       OutValid,
    input  logic       OutReady,
    output logic       Done,
    output logic [3:0] TapIdx,
    output logic [6:0] LfsrInit,
    output logic       NoMatch,
    output logic       Ambig,
    output logic [6:0] ParErrCnt
);

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [6:0]            cur_q, cur_d;
    logic [NUM_PTRN-1:0]   mask_q, mask_d;
    logic [3:0]            tapIdx_q, tapIdx_d;
    logic [6:0]            lfsrInit_q, lfsrInit_d;
    logic                  noMatch_q, noMatch_d;
    logic                  ambig_q, ambig_d;
    logic                  seen_q, seen_d;
    logic                  outValid_q, outValid_d;
    logic [7:0]            outData_q, outData_d;

    logic [6:0]            trainNext [NUM_PTRN];
    logic [6:0]            selNext;
    logic [7:0]            plain;
    logic                  inFire;
    logic                  startFrame;

    // One predictor per candidate pattern during training, plus one for the
    // pattern chosen at the end of training.
    for (genvar k = 0; k < NUM_PTRN; k++) begin : g_train
        lfsr_next u_next (
            .state_i (cur_q),
            .ptrn_i  (LFSR_PTRN[k]),
            .next_o  (trainNext[k])
        );
    end

    lfsr_next u_sel (
        .state_i (cur_q),
        .ptrn_i  (LFSR_PTRN[tapIdx_q]),
        .next_o  (selNext)
    );

    // Input is accepted in DECODE only when the output slot will be free
    // at the next edge, which keeps the one-deep output register lossless.
    assign InReady    = (state_q == TRAIN) ||
                        ((state_q == DECODE) && (!outValid_q || OutReady));
    assign inFire     = InReady && InValid;
    assign startFrame = Start && ((state_q == IDLE) || (state_q == DONE));
    assign plain      = {1'b0, InData[6:0] ^ selNext} + 8'h20;

    // Next-state and datapath update for the frame controller.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        mask_d     = mask_q;
        tapIdx_d   = tapIdx_q;
        lfsrInit_d = lfsrInit_q;
        noMatch_d  = noMatch_q;
        ambig_d    = ambig_q;
        seen_d     = seen_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;

        if (outValid_q && OutReady) outValid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d    = TRAIN;
                    cnt_d      = '0;
                    cur_d      = '0;
                    mask_d     = '0;
                    tapIdx_d   = '0;
                    lfsrInit_d = '0;
                    noMatch_d  = 1'b0;
                    ambig_d    = 1'b0;
                    seen_d     = 1'b0;
                    outValid_d = 1'b0;
                    outData_d  = '0;
                end
            end
            TRAIN: begin
                if (inFire) begin
                    cnt_d = cnt_q + 6'd1;
                    cur_d = InData[6:0];
                    if (cnt_q == 6'd0) begin
                        lfsrInit_d = InData[6:0];
                        mask_d     = '1;
                    end else begin
                        for (int i = 0; i < NUM_PTRN; i++) begin
                            if (InData[6:0] != trainNext[i]) mask_d[i] = 1'b0;
                        end
                    end
                    // The verdict includes the elimination done by the last
                    // training byte, hence mask_d rather than mask_q.
                    if (cnt_q == 6'(TRAIN_LEN - 1)) begin
                        state_d   = DECODE;
                        tapIdx_d  = lowestSet(mask_d);
                        ambig_d   = multiSet(mask_d);
                        noMatch_d = (mask_d == '0);
                    end
                end
            end
            DECODE: begin
                if (inFire) begin
                    cnt_d = cnt_q + 6'd1;
                    cur_d = selNext;
                    if (!noMatch_q && ((plain != 8'h20) || seen_q)) begin
                        outValid_d = 1'b1;
                        outData_d  = plain;
                        seen_d     = 1'b1;
                    end
                    if (cnt_q == 6'(FRAME_LEN - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!outValid_q) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller and datapath registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            mask_q     <= '0;
            tapIdx_q   <= '0;
            lfsrInit_q <= '0;
            noMatch_q  <= 1'b0;
            ambig_q    <= 1'b0;
            seen_q     <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            mask_q     <= mask_d;
            tapIdx_q   <= tapIdx_d;
            lfsrInit_q <= lfsrInit_d;
            noMatch_q  <= noMatch_d;
            ambig_q    <= ambig_d;
            seen_q     <= seen_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
        end
    end

`ifdef DEC_PARITY_CHECK_EN
    logic [6:0] parErr_q, parErr_d;

    // Even parity over the whole byte; the count saturates at 127.
    always_comb begin
        parErr_d = parErr_q;
        if (startFrame) begin
            parErr_d = '0;
        end else if (inFire && (InData[7] != ^InData[6:0]) && (parErr_q != 7'h7F)) begin
            parErr_d = parErr_q + 7'd1;
        end
    end

    // Parity error counter register.
    always_ff @(posedge Clk) begin
        if (!Reset) parErr_q <= '0;
        else        parErr_q <= parErr_d;
    end

    assign ParErrCnt = parErr_q;
`else
    logic unusedParityBit;
    logic unusedStartFrame;

    assign unusedParityBit  = InData[7];
    assign unusedStartFrame = startFrame;
    assign ParErrCnt        = '0;
`endif

    assign OutData  = outData_q;
    assign OutValid = outValid_q;
    assign Done     = (state_q == DONE);
    assign TapIdx   = tapIdx_q;
    assign LfsrInit = lfsrInit_q;
    assign NoMatch  = noMatch_q;
    assign Ambig    = ambig_q;

endmodule

// File: tb/tb_lfsr_decrypt.sv
// ---------------------------------------------------------------------------
// tb_lfsr_decrypt
// Directed bench for lfsr_decrypt. Frames are built by an encryptor model
// (pattern 0x7B, seed 0x01, 13 leading spaces) and the plaintext stream is
// collected and compared against the known message.
// ---------------------------------------------------------------------------
module tb_lfsr_decrypt;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [7:0] InData;
    logic       InValid;
    logic       InReady;
    logic [7:0] OutData;
    logic       OutValid;
    logic       OutReady;
    logic       Done;
    logic [3:0] TapIdx;
    logic [6:0] LfsrInit;
    logic       NoMatch;
    logic       Ambig;
    logic [6:0] ParErrCnt;

    int checks = 0;
    int passes = 0;

    logic [7:0] frame [64];
    logic [7:0] outQ [$];
    logic [7:0] expQ [$];
    string      msg = "Mr. Watson, come here. I want to see you.";

`ifdef DEC_PARITY_CHECK_EN
    localparam logic [6:0] EXP_PAR_ONE = 7'd1;
`else
    localparam logic [6:0] EXP_PAR_ONE = 7'd0;
`endif

    lfsr_decrypt dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .InData    (InData),
        .InValid   (InValid),
        .InReady   (InReady),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Done      (Done),
        .TapIdx    (TapIdx),
        .LfsrInit  (LfsrInit),
        .NoMatch   (NoMatch),
        .Ambig     (Ambig),
        .ParErrCnt (ParErrCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [6:0] lfsrStep(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    // Encrypts 13 spaces + message + 10 spaces with pattern 0x7B, seed 0x01.
    task automatic buildWatson();
        logic [7:0] plainText [64];
        logic [6:0] s;
        logic [7:0] off;
        logic [6:0] enc;
        for (int i = 0; i < 64; i++) plainText[i] = 8'h20;
        for (int j = 0; j < msg.len(); j++) plainText[13 + j] = msg[j];
        s = 7'h01;
        for (int i = 0; i < 64; i++) begin
            off      = plainText[i] - 8'h20;
            enc      = off[6:0] ^ s;
            frame[i] = {^enc, enc};
            s        = lfsrStep(s, 7'h7B);
        end
        expQ.delete();
        for (int j = 0; j < msg.len(); j++) expQ.push_back(msg[j]);
        for (int j = 0; j < 10; j++) expQ.push_back(8'h20);
    endtask

    task automatic fillFrame(input logic [7:0] v);
        for (int i = 0; i < 64; i++) frame[i] = v;
    endtask

    function automatic int streamDiffs();
        int bad = 0;
        for (int i = 0; i < outQ.size() && i < expQ.size(); i++) begin
            if (outQ[i] !== expQ[i]) bad++;
        end
        return bad;
    endfunction

    task automatic doStart();
        @(posedge Clk); #1;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    // Streams frame[] into the DUT and collects output bytes until Done,
    // an optional abort point, or the cycle budget. Optionally holds
    // OutReady low for 20 cycles once stallAfter bytes have come out.
    task automatic runFrame(input int stallAfter, input int abortAt, output int stallViol);
        int idx;
        int stallCyc;
        bit inFire;
        bit outFire;
        bit stalling;
        bit stallDone;
        idx = 0; stallCyc = 0; stalling = 1'b0; stallDone = 1'b0; stallViol = 0;
        outQ.delete();
        OutReady = 1'b1;
        InValid  = 1'b1;
        InData   = frame[0];
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge Clk);
            inFire  = InValid && InReady;
            outFire = OutValid && OutReady;
            if (outFire) outQ.push_back(OutData);
            if (stalling && stallCyc >= 2 && InReady) stallViol++;
            if (Done) break;
            @(posedge Clk); #1;
            if (inFire) idx++;
            if (abortAt >= 0 && idx == abortAt) break;
            InValid = (idx < 64);
            if (idx < 64) InData = frame[idx];
            else          InData = 8'h00;
            if (stalling) begin
                stallCyc++;
                if (stallCyc >= 20) begin
                    stalling  = 1'b0;
                    stallDone = 1'b1;
                    OutReady  = 1'b1;
                end
            end else if (!stallDone && stallAfter >= 0 && outQ.size() >= stallAfter) begin
                stalling = 1'b1;
                stallCyc = 0;
                OutReady = 1'b0;
            end
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
    endtask

    task automatic test_reset();
        logic [30:0] vec;
        Reset = 1'b0; Start = 1'b1; InValid = 1'b0; InData = 8'h00; OutReady = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        vec = {InReady, OutValid, OutData, Done, TapIdx, LfsrInit, NoMatch, Ambig, ParErrCnt};
        checks++;
        if (vec !== 31'd0) $display("[TB] FAIL reset_outputs got %h want 0", vec);
        else passes++;
        @(posedge Clk); #1;
        Reset = 1'b1; Start = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks++;
        if ({InReady, Done} !== 2'b00)
            $display("[TB] FAIL start_in_reset InReady/Done got %b want 00", {InReady, Done});
        else passes++;
    endtask

    task automatic test_watson();
        int viol;
        buildWatson();
        doStart();
        runFrame(-1, -1, viol);
        checks++;
        if (Done !== 1'b1) $display("[TB] FAIL watson_done got %b want 1", Done); else passes++;
        checks++;
        if (TapIdx !== 4'd8) $display("[TB] FAIL watson_tapidx got %0d want 8", TapIdx); else passes++;
        checks++;
        if (LfsrInit !== 7'h01) $display("[TB] FAIL watson_init got %h want 01", LfsrInit); else passes++;
        checks++;
        if ({Ambig, NoMatch} !== 2'b00) $display("[TB] FAIL watson_flags got %b want 00", {Ambig, NoMatch}); else passes++;
        checks++;
        if (ParErrCnt !== 7'd0) $display("[TB] FAIL watson_parerr got %0d want 0", ParErrCnt); else passes++;
        checks++;
        if (outQ.size() != 51) $display("[TB] FAIL watson_len got %0d want 51", outQ.size()); else passes++;
        checks++;
        if (streamDiffs() != 0) $display("[TB] FAIL watson_stream got %0d differing bytes want 0", streamDiffs()); else passes++;
    endtask

    task automatic test_parity();
        int viol;
        buildWatson();
        frame[20] = frame[20] ^ 8'h80;
        doStart();
        runFrame(-1, -1, viol);
        checks++;
        if (ParErrCnt !== EXP_PAR_ONE) $display("[TB] FAIL parity_count got %0d want %0d", ParErrCnt, EXP_PAR_ONE); else passes++;
        checks++;
        if (outQ.size() != 51 || streamDiffs() != 0)
            $display("[TB] FAIL parity_stream got len %0d diffs %0d want len 51 diffs 0", outQ.size(), streamDiffs());
        else passes++;
    endtask

    task automatic test_no_match();
        int viol;
        fillFrame(8'h55);
        doStart();
        runFrame(-1, -1, viol);
        checks++;
        if (Done !== 1'b1) $display("[TB] FAIL nomatch_done got %b want 1", Done); else passes++;
        checks++;
        if (NoMatch !== 1'b1) $display("[TB] FAIL nomatch_flag got %b want 1", NoMatch); else passes++;
        checks++;
        if (outQ.size() != 0) $display("[TB] FAIL nomatch_len got %0d want 0", outQ.size()); else passes++;
        checks++;
        if (ParErrCnt !== 7'd0) $display("[TB] FAIL nomatch_parerr_cleared got %0d want 0", ParErrCnt); else passes++;
    endtask

    task automatic test_all_zero();
        int viol;
        fillFrame(8'h00);
        doStart();
        checks++;
        if ({Done, NoMatch} !== 2'b00) $display("[TB] FAIL restart_clear Done/NoMatch got %b want 00", {Done, NoMatch}); else passes++;
        runFrame(-1, -1, viol);
        checks++;
        if (Done !== 1'b1) $display("[TB] FAIL zero_done got %b want 1", Done); else passes++;
        checks++;
        if ({Ambig, NoMatch, TapIdx} !== 6'b10_0000)
            $display("[TB] FAIL zero_flags Ambig/NoMatch/TapIdx got %b/%b/%0d want 1/0/0", Ambig, NoMatch, TapIdx);
        else passes++;
        checks++;
        if (outQ.size() != 0) $display("[TB] FAIL zero_len got %0d want 0", outQ.size()); else passes++;
    endtask

    task automatic test_stall();
        int viol;
        buildWatson();
        doStart();
        runFrame(20, -1, viol);
        checks++;
        if (viol != 0) $display("[TB] FAIL stall_inready got %0d cycles with InReady=1 want 0", viol); else passes++;
        checks++;
        if (outQ.size() != 51 || streamDiffs() != 0)
            $display("[TB] FAIL stall_stream got len %0d diffs %0d want len 51 diffs 0", outQ.size(), streamDiffs());
        else passes++;
        checks++;
        if (Done !== 1'b1) $display("[TB] FAIL stall_done got %b want 1", Done); else passes++;
    endtask

    task automatic test_midframe_reset();
        int viol;
        logic [30:0] vec;
        buildWatson();
        doStart();
        runFrame(-1, 31, viol);
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        vec = {InReady, OutValid, OutData, Done, TapIdx, LfsrInit, NoMatch, Ambig, ParErrCnt};
        checks++;
        if (vec !== 31'd0) $display("[TB] FAIL midreset_outputs got %h want 0", vec); else passes++;
        doStart();
        runFrame(-1, -1, viol);
        checks++;
        if (Done !== 1'b1 || TapIdx !== 4'd8) $display("[TB] FAIL midreset_rerun Done/TapIdx got %b/%0d want 1/8", Done, TapIdx); else passes++;
        checks++;
        if (outQ.size() != 51 || streamDiffs() != 0)
            $display("[TB] FAIL midreset_stream got len %0d diffs %0d want len 51 diffs 0", outQ.size(), streamDiffs());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_watson();
        test_parity();
        test_no_match();
        test_all_zero();
        test_stall();
        test_midframe_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_decrypt.md
LFSR_DECRYPT -- requirements
Module: lfsr_decrypt

Interface
REQ-001 SHALL have port Clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port Start, input, 1; a high pulse launches one 64-byte frame decrypt.
REQ-004 SHALL have ports InData (input, 8, encrypted byte, parity in bit 7), InValid (input, 1) and InReady (output, 1); a byte transfers when both are high.
REQ-005 SHALL have ports OutData (output, 8, plaintext ASCII), OutValid (output, 1) and OutReady (input, 1); a byte transfers when both are high.
REQ-006 SHALL have port Done, output, 1; high while the frame is finished.
REQ-007 SHALL have ports TapIdx (output, 4, detected pattern 0..8), LfsrInit (output, 7, byte0[6:0]), NoMatch (output, 1), Ambig (output, 1) and ParErrCnt (output, 7).

Function
REQ-008 SHALL implement states IDLE, TRAIN, DECODE, DRAIN and DONE.
REQ-009 SHALL move IDLE->TRAIN on Start; DONE->TRAIN on Start, clearing all flags, counters and Done; Start in TRAIN, DECODE or DRAIN is ignored.
REQ-010 SHALL count accepted bytes 0..63 with a 6-bit counter; TRAIN covers bytes 0..9, DECODE covers bytes 10..63, and byte 63 accepted -> DRAIN.
REQ-011 SHALL hold InReady=1 in TRAIN; in DECODE, InReady=1 when the output register is empty or OutReady=1; InReady=0 otherwise.
REQ-012 SHALL use next(s,p) = {s[5:0], ^(s & p)} over 7 bits; byte0 loads cur=LfsrInit=byte0[6:0] and sets a 9-bit candidate mask to all ones.
REQ-013 SHALL, for TRAIN bytes 1..9, clear mask[k] when byte[6:0] != next(cur, PTRN[k]), then set cur=byte[6:0].
REQ-014 SHALL, at DECODE entry, set TapIdx to the lowest set mask bit; set Ambig=1 when more than one bit is set; set NoMatch=1 and TapIdx=0 when the mask is zero.
REQ-015 SHALL, for each DECODE byte, compute e=next(cur, PTRN[TapIdx]), set plain={1'b0, byte[6:0]^e}+8'h20 and set cur=e.
REQ-016 SHALL suppress output of plain==8'h20 until the first non-space plaintext byte of the frame; after that, all bytes including trailing spaces are emitted.
REQ-017 SHALL, when NoMatch=1, consume the remaining bytes and emit nothing.
REQ-018 SHALL emit through a one-deep output register: OutValid rises the cycle after the input handshake and is held with stable OutData until OutReady.
REQ-019 SHALL leave DRAIN for DONE when the output register is empty; Done=1 from the following cycle until the next Start.
REQ-020 SHALL never drop, duplicate or reorder bytes under any OutReady pattern.

Reset
REQ-021 SHALL, with Reset low at a clock edge, enter IDLE and clear InReady, OutValid, OutData, Done, TapIdx, LfsrInit, NoMatch, Ambig, ParErrCnt, the mask and the counters, in any state including mid-frame.
REQ-022 SHALL ignore Start in any cycle where Reset is low.

Configuration
REQ-023 SHALL, with macro DEC_PARITY_CHECK_EN defined, increment ParErrCnt, saturating at 127, for every accepted byte with byte[7] != ^byte[6:0]; data still decodes.
REQ-024 SHALL, without DEC_PARITY_CHECK_EN, ignore bit 7 and tie ParErrCnt to 0.

Structure
REQ-025 SHALL place the following in shared package dec_pkg: the state enum, FRAME_LEN=64, TRAIN_LEN=10 and LFSR_PTRN[9] = 60,48,78,72,6A,69,5C,7E,7B (hex).
REQ-026 SHALL implement next() as combinational sub-module lfsr_next, instanced once per pattern in TRAIN plus once for the selected pattern.

Verification
REQ-027 SHALL cover: pattern 0x7B, init 0x01, pre-length 13, "Mr. Watson, come here. I want to see you." encrypted as 64 bytes -> TapIdx=8, LfsrInit=0x01, Ambig=0, output is the 41 message chars then 10 spaces, Done=1.
REQ-028 SHALL cover: the same frame with bit 7 of byte 20 flipped -> ParErrCnt=1 and identical OutData stream (with macro); ParErrCnt=0 (without macro).
REQ-029 SHALL cover: 64 bytes of 0x55 -> NoMatch=1, zero output bytes, Done=1.
REQ-030 SHALL cover: an all-0x00 frame -> Ambig=1, TapIdx=0, zero output bytes, Done=1.
REQ-031 SHALL cover: OutReady held low 20 cycles mid-DECODE -> InReady=0 during the stall and the complete stream matches the first scenario.
REQ-032 SHALL cover: Reset low for 1 cycle after byte 30 -> IDLE with all outputs 0; a following Start and full frame decodes correctly.
